// File: rtl/io_pkg.sv
// Shared constants for the buffered bus I/O port: read-select encoding and
// status-word bit positions.
package io_pkg;
  localparam logic IO_SEL_RX     = 1'b0;
  localparam logic IO_SEL_STATUS = 1'b1;

  localparam int IO_ST_TX_EMPTY = 0;
  localparam int IO_ST_TX_FULL  = 1;
  localparam int IO_ST_RX_FULL  = 2;
  localparam int IO_ST_OVF      = 3;
  localparam int IO_ST_CNT_LSB  = 4;
endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a write into a full FIFO is only
// accepted when a pop frees a slot on the same edge.
module io_sync_fifo #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_req,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop_req,
  output logic [WIDTH-1:0]  rdata,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow_evt
);
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign pop          = pop_req && !empty;
  assign push         = push_req && (!full || pop);
  assign overflow_evt = push_req && full && !pop;
  assign count        = wr_ptr - rd_ptr;
  assign rdata        = mem[rd_ptr[ADDR_W-1:0]];

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[ADDR_W-1:0]] <= wdata;
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/tri_state_buffer.sv
// Drives a shared bus with data while en is high, releases it (Z) otherwise.
module tri_state_buffer #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  output tri   [WIDTH-1:0] out
);
  assign out = en ? data : {WIDTH{1'bz}};
endmodule

// File: rtl/io_port_buffered.sv
// Bus I/O port: bus writes queue into a TX FIFO drained over valid/ready, a
// one-entry RX register fills over valid/ready, bus reads return RX or status.
module io_port_buffered
  import io_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             IO_clock,
  input  logic             IO_reset,
  input  logic [WIDTH-1:0] bus_IO_input,
  input  logic             bus_IO_input_en,
  output tri   [WIDTH-1:0] bus_IO_output,
  input  logic             bus_IO_output_en,
  input  logic             bus_IO_sel,
  output logic [WIDTH-1:0] external_IO_output,
  output logic             external_IO_output_valid,
  input  logic             external_IO_output_ready,
  input  logic [WIDTH-1:0] external_IO_input,
  input  logic             external_IO_input_valid,
  output logic             external_IO_input_ready
);
  localparam int ADDR_W = $clog2(DEPTH);

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // a producer holding valid keeps its data stable until that edge, and ready
  // never depends combinationally on valid.

  logic              tx_empty;
  logic              tx_full;
  logic [ADDR_W:0]   tx_count;
  logic              ovf_evt;
  logic              overflow;
  logic              rx_full;
  logic [WIDTH-1:0]  rx_data;
  logic [WIDTH-1:0]  status_word;
  logic [WIDTH-1:0]  bus_data;
  logic              rd_rx;
  logic              rd_status;

  io_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk          (IO_clock),
    .rst_n        (IO_reset),
    .push_req     (bus_IO_input_en),
    .wdata        (bus_IO_input),
    .pop_req      (external_IO_output_ready),
    .rdata        (external_IO_output),
    .empty        (tx_empty),
    .full         (tx_full),
    .count        (tx_count),
    .overflow_evt (ovf_evt)
  );

  assign external_IO_output_valid = !tx_empty;
  assign external_IO_input_ready  = !rx_full;
  assign rd_rx     = bus_IO_output_en && (bus_IO_sel == IO_SEL_RX);
  assign rd_status = bus_IO_output_en && (bus_IO_sel == IO_SEL_STATUS);

  // An overflow on the same edge as a status read keeps the flag set.
  always_ff @(posedge IO_clock or negedge IO_reset) begin
    if (!IO_reset) begin
      overflow <= 1'b0;
      rx_full  <= 1'b0;
      rx_data  <= '0;
    end else begin
      if (ovf_evt)        overflow <= 1'b1;
      else if (rd_status) overflow <= 1'b0;

      if (external_IO_input_valid && !rx_full) begin
        rx_data <= external_IO_input;
        rx_full <= 1'b1;
      end else if (rd_rx) begin
        rx_full <= 1'b0;
      end
    end
  end

  always_comb begin
    status_word                               = '0;
    status_word[IO_ST_TX_EMPTY]               = tx_empty;
    status_word[IO_ST_TX_FULL]                = tx_full;
    status_word[IO_ST_RX_FULL]                = rx_full;
    status_word[IO_ST_OVF]                    = overflow;
    status_word[IO_ST_CNT_LSB +: ADDR_W + 1]  = tx_count;
  end

  assign bus_data = (bus_IO_sel == IO_SEL_STATUS) ? status_word : rx_data;

  tri_state_buffer #(.WIDTH(WIDTH)) u_bus_drv (
    .data (bus_data),
    .en   (bus_IO_output_en),
    .out  (bus_IO_output)
  );
endmodule

// File: tb/tb_io_port_buffered.sv
// Directed bench for io_port_buffered with a queue-based reference model that
// is checked every cycle, plus hand-computed literal expectations.
module tb_io_port_buffered;
  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         IO_clock = 1'b0;
  logic         IO_reset = 1'b0;
  logic [W-1:0] bus_in   = '0;
  logic         bus_in_en = 1'b0;
  tri1  [W-1:0] bus_out;
  logic         bus_out_en = 1'b0;
  logic         bus_sel    = 1'b0;
  logic [W-1:0] ext_out;
  logic         ext_out_valid;
  logic         ext_out_ready = 1'b0;
  logic [W-1:0] ext_in    = '0;
  logic         ext_in_valid = 1'b0;
  logic         ext_in_ready;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  logic         m_rx_full = 1'b0;
  logic [W-1:0] m_rx_data = '0;
  logic         m_ovf     = 1'b0;

  io_port_buffered #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .IO_clock                 (IO_clock),
    .IO_reset                 (IO_reset),
    .bus_IO_input             (bus_in),
    .bus_IO_input_en          (bus_in_en),
    .bus_IO_output            (bus_out),
    .bus_IO_output_en         (bus_out_en),
    .bus_IO_sel               (bus_sel),
    .external_IO_output       (ext_out),
    .external_IO_output_valid (ext_out_valid),
    .external_IO_output_ready (ext_out_ready),
    .external_IO_input        (ext_in),
    .external_IO_input_valid  (ext_in_valid),
    .external_IO_input_ready  (ext_in_ready)
  );

  // Clock / watchdog
  always #5 IO_clock = ~IO_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_status();
    int n;
    n = exp_q.size();
    return W'(n * 16 + (m_ovf ? 8 : 0) + (m_rx_full ? 4 : 0) +
              ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0));
  endfunction

  // Model update: applies the port's rules to the inputs seen at each edge
  always @(posedge IO_clock or negedge IO_reset) begin
    if (!IO_reset) begin
      exp_q.delete();
      m_rx_full = 1'b0;
      m_rx_data = '0;
      m_ovf     = 1'b0;
    end else begin
      logic did_pop;
      logic ovf_now;
      did_pop = (exp_q.size() > 0) && ext_out_ready;
      ovf_now = 1'b0;
      if (did_pop) void'(exp_q.pop_front());
      if (bus_in_en) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(bus_in);
        else ovf_now = 1'b1;
      end
      if (ovf_now) m_ovf = 1'b1;
      else if (bus_out_en && bus_sel) m_ovf = 1'b0;
      if (ext_in_valid && !m_rx_full) begin
        m_rx_data = ext_in;
        m_rx_full = 1'b1;
      end else if (bus_out_en && !bus_sel) begin
        m_rx_full = 1'b0;
      end
    end
  end

  // Per-cycle compare, mid low phase after inputs have settled
  always @(negedge IO_clock) begin
    #2;
    if (IO_reset) begin
      chk("valid", W'(ext_out_valid), W'(exp_q.size() != 0));
      chk("input_ready", W'(ext_in_ready), W'(!m_rx_full));
      if (exp_q.size() != 0) chk("head", ext_out, exp_q[0]);
      if (!bus_out_en)   chk("bus_z", bus_out, 16'hFFFF);
      else if (bus_sel)  chk("bus_status", bus_out, m_status());
      else               chk("bus_rx", bus_out, m_rx_data);
    end
  end

  // Driver: one call = one cycle of inputs, applied at the falling edge
  task automatic drive(input logic we, input logic [W-1:0] wd, input logic rdy,
                       input logic re, input logic sel,
                       input logic xv, input logic [W-1:0] xd);
    @(negedge IO_clock);
    bus_in_en     = we;
    bus_in        = wd;
    ext_out_ready = rdy;
    bus_out_en    = re;
    bus_sel       = sel;
    ext_in_valid  = xv;
    ext_in        = xd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic fill(input logic [W-1:0] base);
    for (int i = 1; i <= DEPTH; i++)
      drive(1'b1, base + W'(i), 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // Power-on reset values
    #3;
    chk("rst_valid", W'(ext_out_valid), 16'h0);
    chk("rst_head", ext_out, 16'h0);
    chk("rst_input_ready", W'(ext_in_ready), 16'h1);
    chk("rst_bus_z", bus_out, 16'hFFFF);
    bus_out_en = 1'b1; bus_sel = 1'b1;
    #1;
    chk("rst_status", bus_out, 16'h0001);
    @(negedge IO_clock);
    IO_reset = 1'b1;
    idle();

    // 1: reset mid-traffic with 3 entries queued and RX full
    drive(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777);
    drive(1'b1, 16'h1112, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 16'h1113, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(); settle();
    chk("t1_pre_input_ready", W'(ext_in_ready), 16'h0);
    @(negedge IO_clock);
    IO_reset = 1'b0;
    settle();
    chk("t1_valid", W'(ext_out_valid), 16'h0);
    chk("t1_head", ext_out, 16'h0);
    chk("t1_input_ready", W'(ext_in_ready), 16'h1);
    chk("t1_bus_z", bus_out, 16'hFFFF);
    bus_out_en = 1'b1; bus_sel = 1'b1;
    #1;
    chk("t1_status", bus_out, 16'h0001);
    @(negedge IO_clock);
    IO_reset = 1'b1;
    bus_out_en = 1'b0; bus_sel = 1'b0;

    // 2: fill with ready low, then drain in order
    fill(16'hA000);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0); settle();
    chk("t2_status_full", bus_out, 16'h0042);
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0); settle();
      chk("t2_head", ext_out, 16'hA000 + W'(i));
    end
    idle(); settle();
    chk("t2_drained", W'(ext_out_valid), 16'h0);

    // 3: overflow drop, sticky flag, read clear, overflow beats same-cycle clear
    fill(16'h3000);
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0); settle();
    chk("t3_status_ovf", bus_out, 16'h004A);
    drive(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b1, 1'b0, '0); settle();
    chk("t3_status_cleared", bus_out, 16'h0042);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0); settle();
    chk("t3_status_ovf_wins", bus_out, 16'h004A);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0); settle();
    chk("t3_status_after", bus_out, 16'h0042);
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0); settle();
      chk("t3_head", ext_out, 16'h3000 + W'(i));
    end
    idle(); settle();
    chk("t3_drained", W'(ext_out_valid), 16'h0);

    // 4: write into full FIFO while a pop happens
    fill(16'h4000);
    drive(1'b1, 16'hC0DE, 1'b1, 1'b0, 1'b0, 1'b0, '0); settle();
    chk("t4_head_popped", ext_out, 16'h4001);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0); settle();
    chk("t4_status", bus_out, 16'h0042);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0); settle();
      if (i == DEPTH - 1) chk("t4_last", ext_out, 16'hC0DE);
    end
    idle(); settle();
    chk("t4_drained", W'(ext_out_valid), 16'h0);

    // 5: RX holding register handshake
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234); settle();
    chk("t5_ready_before", W'(ext_in_ready), 16'h1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5678); settle();
    chk("t5_ready_full", W'(ext_in_ready), 16'h0);
    chk("t5_status_rx", bus_out, 16'h0005);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5678); settle();
    chk("t5_rx_read", bus_out, 16'h1234);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5678); settle();
    chk("t5_ready_again", W'(ext_in_ready), 16'h1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0); settle();
    chk("t5_ready_held", W'(ext_in_ready), 16'h0);
    chk("t5_rx_read2", bus_out, 16'h5678);
    idle(); settle();
    chk("t5_ready_final", W'(ext_in_ready), 16'h1);

    // 6: write to empty FIFO with ready held high
    drive(1'b1, 16'h6006, 1'b1, 1'b0, 1'b0, 1'b0, '0); settle();
    chk("t6_valid_latency", W'(ext_out_valid), 16'h0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0); settle();
    chk("t6_valid", W'(ext_out_valid), 16'h1);
    chk("t6_head", ext_out, 16'h6006);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0); settle();
    chk("t6_single_pop", W'(ext_out_valid), 16'h0);
    chk("t6_bus_z", bus_out, 16'hFFFF);
    idle(); idle();

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
